// File: rtl/metronome_pkg.sv
// Shared metronome definitions: sequencer state encoding, tempo range
// defaults common with the band/button path, and the accumulator sizing helper.
package metronome_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int BPM_MIN_DEFAULT = 30;
    localparam int BPM_MAX_DEFAULT = 240;

    // Bits needed for the phase accumulator: ceil(log2(CLK_HZ*60 + BPM_MAX)).
    function automatic int acc_width(input longint clk_hz, input longint bpm_max);
        longint limit;
        int     w;
        limit = clk_hz * 60 + bpm_max;
        w     = 1;
        while ((longint'(1) << w) < limit) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/bell_gate.sv
// Retriggerable gate: a down-counter that is loaded on a strobe, cleared by
// cut, and holds the output high while non-zero. Reusable for a tone generator.
module bell_gate #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          cut,
    output logic          bell
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: cut wins, a load restarts the count, otherwise count down to zero.
    always_comb begin
        // NOTE: assign a default first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (cut) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments in clocked blocks so all flops update together.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bell = (cnt_q != '0);

endmodule

// File: rtl/beat_scheduler.sv
// Tempo sequencer: clamps the BPM setting, turns it into beat strobes with a
// divider-free phase accumulator, tracks the position in the bar, flags the
// downbeat accent and drives the bell gate.
// Optional half-beat subdivision (subdiv input, sub_pulse output) is built
// when BEAT_SUBDIV_EN is defined.
module beat_scheduler
    import metronome_pkg::*;
#(
    parameter int CLK_HZ    = 100000000,
    parameter int BPM_MIN   = BPM_MIN_DEFAULT,
    parameter int BPM_MAX   = BPM_MAX_DEFAULT,
    parameter int BELL_CYC  = 5000000,
    parameter int MAX_BEATS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef BEAT_SUBDIV_EN
    input  logic       subdiv,
    output logic       sub_pulse,
`endif
    input  logic       play,
    input  logic [7:0] bpm,
    input  logic [2:0] bar_len,
    output logic       beat_pulse,
    output logic       accent,
    output logic [2:0] beat_idx,
    output logic       bell,
    output logic       running
);

    localparam longint THR = longint'(CLK_HZ) * 60;
    localparam int     AW  = acc_width(longint'(CLK_HZ), longint'(BPM_MAX));
    localparam int     BW  = $clog2(2 * BELL_CYC + 1);

    localparam logic [AW-1:0] THR_V     = AW'(THR);
    localparam logic [7:0]    BPM_MIN_V = 8'(BPM_MIN);
    localparam logic [7:0]    BPM_MAX_V = 8'(BPM_MAX);
    localparam logic [3:0]    MAX_LEN_V = 4'(MAX_BEATS);
    localparam logic [BW-1:0] BELL_NORM = BW'(BELL_CYC);
    localparam logic [BW-1:0] BELL_ACC  = BW'(2 * BELL_CYC);
`ifdef BEAT_SUBDIV_EN
    localparam logic [AW-1:0] HALF_V    = AW'(THR / 2);
    localparam logic [BW-1:0] BELL_SUB  = BW'(BELL_CYC / 2);
`endif

    state_e        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [2:0]    beat_idx_q, beat_idx_d;
    logic          beat_pulse_q, beat_pulse_d;
    logic          accent_q, accent_d;
`ifdef BEAT_SUBDIV_EN
    logic          sub_pulse_q, sub_pulse_d;
`endif

    logic [7:0]    bpm_c;
    logic [3:0]    eff_len;
    logic [AW-1:0] acc_sum;
    logic          beat_hit;
    logic [3:0]    idx_inc;
    logic [2:0]    idx_adv;
    logic          bell_load;
    logic          bell_cut;
    logic [BW-1:0] bell_val;

    // Tempo clamp, effective bar length, accumulator step and next beat position.
    always_comb begin
        bpm_c = bpm;
        if (bpm < BPM_MIN_V) begin
            bpm_c = BPM_MIN_V;
        end else if (bpm > BPM_MAX_V) begin
            bpm_c = BPM_MAX_V;
        end

        eff_len = {1'b0, bar_len};
        if (bar_len == 3'd0) begin
            eff_len = 4'd1;
        end else if ({1'b0, bar_len} > MAX_LEN_V) begin
            eff_len = MAX_LEN_V;
        end

        acc_sum  = acc_q + AW'(bpm_c);
        beat_hit = (acc_sum >= THR_V);
        idx_inc  = {1'b0, beat_idx_q} + 4'd1;
        idx_adv  = (idx_inc >= eff_len) ? 3'd0 : idx_inc[2:0];
    end

    // Sequencer next state: start/stop transitions, beat events and bell control.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        beat_idx_d   = beat_idx_q;
        beat_pulse_d = 1'b0;
        accent_d     = 1'b0;
        bell_load    = 1'b0;
        bell_cut     = 1'b0;
        bell_val     = BELL_NORM;
`ifdef BEAT_SUBDIV_EN
        sub_pulse_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (play) begin
                    // Entering RUN fires the downbeat immediately from a zero phase.
                    state_d      = RUN;
                    acc_d        = '0;
                    beat_idx_d   = 3'd0;
                    beat_pulse_d = 1'b1;
                    accent_d     = (bar_len != 3'd0);
                    bell_load    = 1'b1;
                    bell_val     = (bar_len != 3'd0) ? BELL_ACC : BELL_NORM;
                end
            end
            RUN: begin
                if (!play) begin
                    state_d    = IDLE;
                    acc_d      = '0;
                    beat_idx_d = 3'd0;
                    bell_cut   = 1'b1;
                end else if (beat_hit) begin
                    // Carry the remainder so the long-term tempo does not drift.
                    acc_d        = acc_sum - THR_V;
                    beat_idx_d   = idx_adv;
                    beat_pulse_d = 1'b1;
                    accent_d     = (idx_adv == 3'd0) && (bar_len != 3'd0);
                    bell_load    = 1'b1;
                    bell_val     = accent_d ? BELL_ACC : BELL_NORM;
                end else begin
                    acc_d = acc_sum;
`ifdef BEAT_SUBDIV_EN
                    // Half-beat strobe on the first step across THR/2; it only
                    // rings the bell when the gate is idle.
                    if (subdiv && (acc_q < HALF_V) && (acc_sum >= HALF_V)) begin
                        sub_pulse_d = 1'b1;
                        if (!bell) begin
                            bell_load = 1'b1;
                            bell_val  = BELL_SUB;
                        end
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer registers; all registered outputs clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            beat_idx_q   <= 3'd0;
            beat_pulse_q <= 1'b0;
            accent_q     <= 1'b0;
`ifdef BEAT_SUBDIV_EN
            sub_pulse_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            beat_idx_q   <= beat_idx_d;
            beat_pulse_q <= beat_pulse_d;
            accent_q     <= accent_d;
`ifdef BEAT_SUBDIV_EN
            sub_pulse_q  <= sub_pulse_d;
`endif
        end
    end

    bell_gate #(
        .CW(BW)
    ) u_bell_gate (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (bell_load),
        .load_val(bell_val),
        .cut     (bell_cut),
        .bell    (bell)
    );

    assign beat_pulse = beat_pulse_q;
    assign accent     = accent_q;
    assign beat_idx   = beat_idx_q;
    assign running    = (state_q == RUN);
`ifdef BEAT_SUBDIV_EN
    assign sub_pulse  = sub_pulse_q;
`endif

endmodule

// File: tb/tb_beat_scheduler.sv
// Bench for beat_scheduler at CLK_HZ=1000 (THR=60000). A scoreboard queue holds
// the expected beats (cycle, index, accent); a negedge monitor pops and compares
// them as beat_pulse appears. A second instance with BELL_CYC=800 shares the
// stimulus and is examined for bell retriggering.
module tb_beat_scheduler;

    localparam int CLK_HZ = 1000;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       play    = 1'b0;
    logic [7:0] bpm     = 8'd60;
    logic [2:0] bar_len = 3'd4;

    logic       beat_pulse, accent, bell, running;
    logic [2:0] beat_idx;
    logic       rt_beat_pulse, rt_accent, rt_bell, rt_running;
    logic [2:0] rt_beat_idx;
`ifdef BEAT_SUBDIV_EN
    logic       subdiv = 1'b0;
    logic       sub_pulse, rt_sub_pulse;
`endif

    beat_scheduler #(.CLK_HZ(CLK_HZ), .BELL_CYC(100)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef BEAT_SUBDIV_EN
        .subdiv    (subdiv),
        .sub_pulse (sub_pulse),
`endif
        .play      (play),
        .bpm       (bpm),
        .bar_len   (bar_len),
        .beat_pulse(beat_pulse),
        .accent    (accent),
        .beat_idx  (beat_idx),
        .bell      (bell),
        .running   (running)
    );

    beat_scheduler #(.CLK_HZ(CLK_HZ), .BELL_CYC(800)) dut_rt (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef BEAT_SUBDIV_EN
        .subdiv    (subdiv),
        .sub_pulse (rt_sub_pulse),
`endif
        .play      (play),
        .bpm       (bpm),
        .bar_len   (bar_len),
        .beat_pulse(rt_beat_pulse),
        .accent    (rt_accent),
        .beat_idx  (rt_beat_idx),
        .bell      (rt_bell),
        .running   (rt_running)
    );

    always #5 clk = ~clk;

    // Number of rising edges so far; read on falling edges.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int idx;
        bit acc;
    } beat_t;

    beat_t exp_q[$];
    int    passed = 0;
    int    total  = 0;
    bit    mon_en = 1'b0;
    int    sub_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic push(input int c, input int idx, input bit a);
        beat_t e;
        e.cyc = c;
        e.idx = idx;
        e.acc = a;
        exp_q.push_back(e);
    endtask

    task automatic go_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Scoreboard monitor: every beat_pulse must match the oldest expected beat.
    always @(negedge clk) begin
        beat_t e;
        if (mon_en) begin
            if (beat_pulse === 1'b1) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat_cycle", cyc, e.cyc);
                    check("beat_idx", beat_idx, e.idx);
                    check("beat_accent", accent, e.acc);
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                check("beat_missing", beat_pulse, 1);
                void'(exp_q.pop_front());
            end
            if (accent === 1'b1 && beat_pulse !== 1'b1) begin
                check("accent_without_beat", accent, 0);
            end
        end
    end

`ifdef BEAT_SUBDIV_EN
    always @(negedge clk) if (sub_pulse === 1'b1) sub_cnt++;
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t;
        int lows;
`ifdef BEAT_SUBDIV_EN
        int s;
        int c0;
`endif
        // Asynchronous reset: outputs clear without a clock edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_beat_pulse", beat_pulse, 0);
        check("rst_accent", accent, 0);
        check("rst_beat_idx", beat_idx, 0);
        check("rst_bell", bell, 0);
        check("rst_running", running, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_running", running, 0);
        mon_en = 1'b1;

        // Steady tempo: 60 BPM, 4 beats per bar.
        t    = cyc;
        play = 1'b1;
        push(t + 1, 0, 1);
        push(t + 1001, 1, 0);
        push(t + 2001, 2, 0);
        push(t + 3001, 3, 0);
        push(t + 4001, 0, 1);
        go_to(t + 1);
        check("start_running", running, 1);
        check("start_bell", bell, 1);
        go_to(t + 200);
        check("accent_bell_last", bell, 1);
        go_to(t + 201);
        check("accent_bell_off", bell, 0);
        go_to(t + 1100);
        check("normal_bell_last", bell, 1);
        go_to(t + 1101);
        check("normal_bell_off", bell, 0);

        // Tempo change mid-beat to 120 BPM: phase is kept.
        go_to(t + 4501);
        bpm = 8'd120;
        push(t + 4751, 1, 0);
        push(t + 5251, 2, 0);

        // 10 BPM clamps to 30 (2000-cycle period).
        go_to(t + 5251);
        bpm = 8'd10;
        push(t + 7251, 3, 0);
        push(t + 9251, 0, 1);

        // 250 BPM clamps to 240 (250-cycle period).
        go_to(t + 9251);
        bpm = 8'd250;
        push(t + 9501, 1, 0);
        push(t + 9751, 2, 0);

        // Stop 50 cycles into a bell gate.
        go_to(t + 9801);
        check("pre_stop_bell", bell, 1);
        play = 1'b0;
        go_to(t + 9802);
        check("stop_bell", bell, 0);
        check("stop_running", running, 0);
        check("stop_beat_idx", beat_idx, 0);

        // Restart: immediate downbeat, then bar length 4 -> 2 while on beat 3.
        go_to(t + 10100);
        play = 1'b1;
        push(t + 10101, 0, 1);
        push(t + 10351, 1, 0);
        push(t + 10601, 2, 0);
        push(t + 10851, 3, 0);
        go_to(t + 10900);
        bar_len = 3'd2;
        push(t + 11101, 0, 1);
        push(t + 11351, 1, 0);

        // Reset mid-run while the bell is ringing.
        go_to(t + 11400);
        check("pre_rst_beat_idx", beat_idx, 1);
        check("pre_rst_bell", bell, 1);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_beat_pulse", beat_pulse, 0);
        check("midrun_rst_accent", accent, 0);
        check("midrun_rst_beat_idx", beat_idx, 0);
        check("midrun_rst_bell", bell, 0);
        check("midrun_rst_running", running, 0);

        // Bar length 0: no accents, index stays 0.
        go_to(t + 11410);
        rst_n   = 1'b1;
        bar_len = 3'd0;
        push(t + 11411, 0, 0);
        push(t + 11661, 0, 0);
        push(t + 11911, 0, 0);
        go_to(t + 12000);
        play = 1'b0;

        // Retrigger on the BELL_CYC=800 instance at 120 BPM.
        go_to(t + 12100);
        check("rt_bell_cut", rt_bell, 0);
        bpm     = 8'd120;
        bar_len = 3'd4;
        play    = 1'b1;
        push(t + 12101, 0, 1);
        push(t + 12601, 1, 0);
        push(t + 13101, 2, 0);
        push(t + 13601, 3, 0);
        push(t + 15601, 0, 1);
        lows = 0;
        for (int c = t + 12101; c <= t + 14400; c++) begin
            go_to(c);
            if (rt_bell !== 1'b1) lows++;
            if (c == t + 13601) bpm = 8'd30;
        end
        check("rt_bell_low_cycles", lows, 0);
        go_to(t + 14401);
        check("rt_bell_restart_end", rt_bell, 0);

        go_to(t + 15700);
        play = 1'b0;
        go_to(t + 15800);
        check("queue_drained", exp_q.size(), 0);
        check("end_running", running, 0);

`ifdef BEAT_SUBDIV_EN
        check("no_sub_when_off", sub_cnt, 0);
        s      = cyc;
        bpm    = 8'd60;
        subdiv = 1'b1;
        play   = 1'b1;
        push(s + 1, 0, 1);
        push(s + 1001, 1, 0);
        push(s + 2001, 2, 0);
        go_to(s + 500);
        check("sub_early", sub_pulse, 0);
        go_to(s + 501);
        check("sub_fire", sub_pulse, 1);
        check("sub_bell_on", bell, 1);
        go_to(s + 550);
        check("sub_bell_last", bell, 1);
        go_to(s + 551);
        check("sub_bell_off", bell, 0);
        go_to(s + 1001);
        subdiv = 1'b0;
        c0     = sub_cnt;
        go_to(s + 2100);
        check("sub_disabled", sub_cnt - c0, 0);
        play = 1'b0;
        go_to(s + 2200);
        check("sub_queue_drained", exp_q.size(), 0);
`endif

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
